// File: rtl/gpio_seq.sv
// GPIO pattern sequencer: replays up to DEPTH {value, delay} steps into the gpio
// data register, sharing the gpio bus port with the CPU (CPU always wins).
module gpio_seq #(
    parameter logic [15:0] BASE_ADDR = 16'h0440,
    parameter logic [15:0] GPIO_ADDR = 16'h0430,
    parameter int          DEPTH     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data,
    output logic [15:0] o_data,
    output logic        o_gp_we,
    output logic [15:0] o_gp_addr,
    output logic [15:0] o_gp_data,
    output logic        o_done
);

    localparam int             IW      = $clog2(DEPTH);
    localparam logic [4:0]     DEPTH_L = 5'(DEPTH);
    localparam logic [IW-1:0]  IDX_ONE = IW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [15:0]     cnt_r, cnt_s;
    logic [4:0]      len_r, len_s;
    logic [4:0]      run_len_r, run_len_s;
    logic            loop_r, loop_s;
    logic            done_r, done_s;
    logic            done_pulse_s;
    logic [15:0]     rd_data_s;

    logic [15:0]     value_mem [DEPTH];
    logic [15:0]     delay_mem [DEPTH];

    logic [15:0]     off_s;
    logic            sel_s;
    logic            wr_ctrl_s, wr_len_s, wr_ptr_s, wr_val_s, wr_dly_s;
    logic            gpio_hit_s;
    logic            grant_s;
    logic            busy_s;
    logic            last_s;
    logic [4:0]      len_clamp_s;

    // Register-block address decode; offset compare also rejects addresses below the base
    assign off_s      = i_addr - BASE_ADDR;
    assign sel_s      = (off_s < 16'd5);
    assign wr_ctrl_s  = i_we && (off_s == 16'd0);
    assign wr_len_s   = i_we && (off_s == 16'd1);
    assign wr_ptr_s   = i_we && (off_s == 16'd2);
    assign wr_val_s   = i_we && (off_s == 16'd3);
    assign wr_dly_s   = i_we && (off_s == 16'd4);

    assign gpio_hit_s  = (i_addr == GPIO_ADDR) || (i_addr == (GPIO_ADDR + 16'd1));
    assign grant_s     = (state_r == ST_EMIT) && i_rst && !gpio_hit_s;
    assign busy_s      = (state_r != ST_IDLE);
    assign last_s      = (5'(idx_r) == (run_len_r - 5'd1));
    assign len_clamp_s = (len_r > DEPTH_L) ? DEPTH_L : len_r;

    // gpio port mux: CPU pass-through except in a sequencer grant cycle
    always_comb begin
        o_gp_we   = i_we;
        o_gp_addr = i_addr;
        o_gp_data = i_data;
        if (grant_s) begin
            o_gp_we   = 1'b1;
            o_gp_addr = GPIO_ADDR;
            o_gp_data = value_mem[idx_r];
        end else begin
            o_gp_we   = i_we;
            o_gp_addr = i_addr;
            o_gp_data = i_data;
        end
    end

    // Read mux for the registered read-data port
    always_comb begin
        rd_data_s = 16'h0000;
        if (sel_s) begin
            case (off_s)
                16'd0:   rd_data_s = {13'h0000, loop_r, done_r, busy_s};
                16'd1:   rd_data_s = {11'h000, len_r};
                16'd2:   rd_data_s = 16'(idx_r);
                16'd3:   rd_data_s = value_mem[ptr_r];
                16'd4:   rd_data_s = delay_mem[ptr_r];
                default: rd_data_s = 16'h0000;
            endcase
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    // Software-visible register updates
    always_comb begin
        len_s  = len_r;
        ptr_s  = ptr_r;
        loop_s = loop_r;
        if (wr_len_s) begin
            len_s = i_data[4:0];
        end else begin
            len_s = len_r;
        end
        if (wr_ptr_s) begin
            ptr_s = i_data[IW-1:0];
        end else if (wr_dly_s) begin
            ptr_s = ptr_r + IDX_ONE;
        end else begin
            ptr_s = ptr_r;
        end
        if (wr_ctrl_s) begin
            loop_s = i_data[2];
        end else begin
            loop_s = loop_r;
        end
    end

    // Sequencer next-state; CTRL stop/start override the normal step flow
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        done_s       = done_r;
        done_pulse_s = 1'b0;
        run_len_s    = run_len_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_IDLE;
            end
            ST_EMIT: begin
                if (grant_s) begin
                    cnt_s   = delay_mem[idx_r];
                    state_s = (delay_mem[idx_r] != 16'h0000) ? ST_WAIT : ST_NEXT;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 16'd1;
                if (cnt_r == 16'd1) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (last_s) begin
                    idx_s = {IW{1'b0}};
                    if (loop_r) begin
                        state_s = ST_EMIT;
                    end else begin
                        state_s      = ST_IDLE;
                        done_s       = 1'b1;
                        done_pulse_s = 1'b1;
                    end
                end else begin
                    idx_s   = idx_r + IDX_ONE;
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (wr_ctrl_s && i_data[1]) begin
            state_s      = ST_IDLE;
            done_s       = done_r;
            done_pulse_s = 1'b0;
        end else if (wr_ctrl_s && i_data[0] && (len_r != 5'd0)) begin
            state_s      = ST_EMIT;
            idx_s        = {IW{1'b0}};
            cnt_s        = 16'h0000;
            done_s       = 1'b0;
            done_pulse_s = 1'b0;
            run_len_s    = len_clamp_s;
        end else begin
            state_s = state_s;
        end
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IW{1'b0}};
            ptr_r     <= {IW{1'b0}};
            cnt_r     <= 16'h0000;
            len_r     <= 5'd0;
            run_len_r <= 5'd0;
            loop_r    <= 1'b0;
            done_r    <= 1'b0;
            o_done    <= 1'b0;
            o_data    <= 16'h0000;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            len_r     <= len_s;
            run_len_r <= run_len_s;
            loop_r    <= loop_s;
            done_r    <= done_s;
            o_done    <= done_pulse_s;
            o_data    <= rd_data_s;
        end
    end

    // Pattern memory keeps its contents across reset
    always_ff @(posedge i_clk) begin
        if (wr_val_s) begin
            value_mem[ptr_r] <= i_data;
        end
        if (wr_dly_s) begin
            delay_mem[ptr_r] <= i_data;
        end
    end

endmodule

// File: tb/tb_gpio_seq.sv
// Self-checking bench for gpio_seq: register vector table plus a gpio-write
// scoreboard keyed on {cycle, value} for the sequencing scenarios.
module tb_gpio_seq;

    localparam logic [15:0] A_CTRL = 16'h0440;
    localparam logic [15:0] A_LEN  = 16'h0441;
    localparam logic [15:0] A_PTR  = 16'h0442;
    localparam logic [15:0] A_VAL  = 16'h0443;
    localparam logic [15:0] A_DLY  = 16'h0444;
    localparam logic [15:0] A_GPIO = 16'h0430;
    localparam logic [15:0] A_IDLE = 16'h0000;

    logic        i_clk, i_rst, i_we;
    logic [15:0] i_addr, i_data;
    logic [15:0] o_data, o_gp_addr, o_gp_data;
    logic        o_gp_we, o_done;

    gpio_seq dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
        .o_data(o_data), .o_gp_we(o_gp_we), .o_gp_addr(o_gp_addr),
        .o_gp_data(o_gp_data), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } gexp_t;

    vec_t  vecs[$];
    gexp_t exp_q[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every gpio data-register write must match the queue head
    always @(negedge i_clk) begin
        if (o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_gp_we === 1'b1 && o_gp_addr === A_GPIO) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_gpio_write: got value %h at cycle %0d, expected none", o_gp_data, cyc);
            end else begin
                gexp_t e;
                e = exp_q.pop_front();
                check("gpio_write_cycle", cyc, e.cyc);
                check("gpio_write_value", {16'h0, o_gp_data}, {16'h0, e.val});
            end
        end
    end

    task automatic push_exp(input int c, input logic [15:0] v);
        gexp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic bus_cycle(input logic we, input logic [15:0] addr, input logic [15:0] data,
                             input logic chk_pass);
        i_we = we; i_addr = addr; i_data = data;
        @(negedge i_clk);
        if (chk_pass) begin
            check("passthru_we", {31'h0, o_gp_we}, {31'h0, we});
            check("passthru_addr", {16'h0, o_gp_addr}, {16'h0, addr});
            check("passthru_data", {16'h0, o_gp_data}, {16'h0, data});
        end
        @(posedge i_clk); #1;
        i_we = 1'b0; i_addr = A_IDLE; i_data = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic read_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
        bus_cycle(1'b0, addr, 16'h0000, 1'b0);
        check(name, {16'h0, o_data}, {16'h0, exp});
    endtask

    task automatic load_step(input int i, input logic [15:0] v, input logic [15:0] d);
        bus_cycle(1'b1, A_PTR, 16'(i), 1'b0);
        bus_cycle(1'b1, A_VAL, v, 1'b0);
        bus_cycle(1'b1, A_DLY, d, 1'b0);
    endtask

    task automatic add_vec(input logic we, input logic [15:0] a, input logic [15:0] d,
                           input logic chk, input logic [15:0] e);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.chk = chk; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        int t, t2, d0;
        i_rst = 1'b0; i_we = 1'b0; i_addr = A_IDLE; i_data = 16'h0000;

        // Register table: reset values, LEN masking, loop bit, memory and PTR wrap
        add_vec(1'b0, A_CTRL, 16'h0000, 1'b1, 16'h0000);
        add_vec(1'b0, A_LEN,  16'h0000, 1'b1, 16'h0000);
        add_vec(1'b0, A_PTR,  16'h0000, 1'b1, 16'h0000);
        add_vec(1'b1, A_LEN,  16'h0005, 1'b0, 16'h0000);
        add_vec(1'b0, A_LEN,  16'h0000, 1'b1, 16'h0005);
        add_vec(1'b1, A_LEN,  16'hFFF4, 1'b0, 16'h0000);
        add_vec(1'b0, A_LEN,  16'h0000, 1'b1, 16'h0014);
        add_vec(1'b1, A_CTRL, 16'h0004, 1'b0, 16'h0000);
        add_vec(1'b0, A_CTRL, 16'h0000, 1'b1, 16'h0004);
        add_vec(1'b1, A_CTRL, 16'h0000, 1'b0, 16'h0000);
        add_vec(1'b0, A_CTRL, 16'h0000, 1'b1, 16'h0000);
        add_vec(1'b1, A_PTR,  16'h0002, 1'b0, 16'h0000);
        add_vec(1'b1, A_VAL,  16'hABCD, 1'b0, 16'h0000);
        add_vec(1'b0, A_VAL,  16'h0000, 1'b1, 16'hABCD);
        add_vec(1'b1, A_DLY,  16'h0007, 1'b0, 16'h0000);
        add_vec(1'b1, A_PTR,  16'h0002, 1'b0, 16'h0000);
        add_vec(1'b0, A_DLY,  16'h0000, 1'b1, 16'h0007);
        add_vec(1'b1, A_PTR,  16'h0007, 1'b0, 16'h0000);
        add_vec(1'b1, A_VAL,  16'h1111, 1'b0, 16'h0000);
        add_vec(1'b1, A_DLY,  16'h0022, 1'b0, 16'h0000);
        add_vec(1'b1, A_VAL,  16'h2222, 1'b0, 16'h0000);
        add_vec(1'b1, A_PTR,  16'h0007, 1'b0, 16'h0000);
        add_vec(1'b0, A_VAL,  16'h0000, 1'b1, 16'h1111);
        add_vec(1'b0, A_DLY,  16'h0000, 1'b1, 16'h0022);
        add_vec(1'b1, A_PTR,  16'h0000, 1'b0, 16'h0000);
        add_vec(1'b0, A_VAL,  16'h0000, 1'b1, 16'h2222);
        add_vec(1'b0, A_GPIO, 16'h0000, 1'b1, 16'h0000);
        add_vec(1'b0, 16'h0431, 16'h0000, 1'b1, 16'h0000);
        add_vec(1'b0, 16'h0445, 16'h0000, 1'b1, 16'h0000);
        add_vec(1'b0, 16'h043F, 16'h0000, 1'b1, 16'h0000);

        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b1;
        check("reset_o_data", {16'h0, o_data}, 32'h0);
        check("reset_o_done", {31'h0, o_done}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus_cycle(vecs[i].we, vecs[i].addr, vecs[i].data, 1'b1);
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), {16'h0, o_data}, {16'h0, vecs[i].exp});
        end

        // Basic 3-step run: grants at t+1, t+5, t+7, done at t+10
        load_step(0, 16'h0001, 16'h0002);
        load_step(1, 16'h0002, 16'h0000);
        load_step(2, 16'h0004, 16'h0001);
        bus_cycle(1'b1, A_LEN, 16'h0003, 1'b0);
        d0 = done_cnt; t = cyc;
        push_exp(t + 1, 16'h0001); push_exp(t + 5, 16'h0002); push_exp(t + 7, 16'h0004);
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        idle(12);
        check("run1_queue_drained", exp_q.size(), 32'd0);
        check("run1_done_count", done_cnt - d0, 32'd1);
        check("run1_done_cycle", done_cyc, t + 10);
        read_chk("run1_ctrl", A_CTRL, 16'h0002);

        // Loop run, then stop during the WAIT of the wrapped step 0
        d0 = done_cnt; t = cyc;
        push_exp(t + 1, 16'h0001); push_exp(t + 5, 16'h0002);
        push_exp(t + 7, 16'h0004); push_exp(t + 10, 16'h0001);
        bus_cycle(1'b1, A_CTRL, 16'h0005, 1'b0);
        idle(10);
        bus_cycle(1'b1, A_CTRL, 16'h0002, 1'b0);
        idle(10);
        check("loop_queue_drained", exp_q.size(), 32'd0);
        check("loop_no_done", done_cnt - d0, 32'd0);
        read_chk("loop_stop_ctrl", A_CTRL, 16'h0000);

        // Contention: three CPU reads of GPIO_ADDR push the grant to t+4
        bus_cycle(1'b1, A_LEN, 16'h0001, 1'b0);
        d0 = done_cnt; t = cyc;
        push_exp(t + 4, 16'h0001);
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        repeat (3) bus_cycle(1'b0, A_GPIO, 16'h5A5A, 1'b1);
        idle(8);
        check("cont_queue_drained", exp_q.size(), 32'd0);
        check("cont_done_count", done_cnt - d0, 32'd1);
        check("cont_done_cycle", done_cyc, t + 8);

        // LEN=0 start is ignored
        bus_cycle(1'b1, A_LEN, 16'h0000, 1'b0);
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        idle(6);
        read_chk("len0_ctrl", A_CTRL, 16'h0002);

        // LEN=20 clamps to 8 zero-delay steps
        for (int i = 0; i < 8; i++) load_step(i, 16'h0100 + 16'(i), 16'h0000);
        bus_cycle(1'b1, A_LEN, 16'h0014, 1'b0);
        t = cyc;
        for (int k = 0; k < 8; k++) push_exp(t + 1 + 2 * k, 16'h0100 + 16'(k));
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        idle(20);
        check("len20_queue_drained", exp_q.size(), 32'd0);
        check("len20_done_cycle", done_cyc, t + 17);
        read_chk("len20_len_readback", A_LEN, 16'h0014);

        // Reset during WAIT of step 0, then rerun and read memory back
        load_step(0, 16'h0001, 16'h0002);
        load_step(1, 16'h0002, 16'h0000);
        load_step(2, 16'h0004, 16'h0001);
        bus_cycle(1'b1, A_LEN, 16'h0003, 1'b0);
        t = cyc;
        push_exp(t + 1, 16'h0001);
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        idle(1);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        check("rst_mid_o_data", {16'h0, o_data}, 32'h0);
        read_chk("rst_mid_ctrl", A_CTRL, 16'h0000);
        read_chk("rst_mid_len", A_LEN, 16'h0000);
        idle(4);
        check("rst_mid_queue_drained", exp_q.size(), 32'd0);
        bus_cycle(1'b1, A_LEN, 16'h0003, 1'b0);
        t = cyc;
        push_exp(t + 1, 16'h0001); push_exp(t + 5, 16'h0002); push_exp(t + 7, 16'h0004);
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        idle(12);
        check("rerun_queue_drained", exp_q.size(), 32'd0);
        bus_cycle(1'b1, A_PTR, 16'h0001, 1'b0);
        read_chk("mem_val1", A_VAL, 16'h0002);
        read_chk("mem_dly1", A_DLY, 16'h0000);
        bus_cycle(1'b1, A_PTR, 16'h0002, 1'b0);
        read_chk("mem_val2", A_VAL, 16'h0004);
        read_chk("mem_dly2", A_DLY, 16'h0001);

        // Restart while in NEXT of step 1: value[0] re-emitted at the next cycle
        d0 = done_cnt; t = cyc;
        push_exp(t + 1, 16'h0001); push_exp(t + 5, 16'h0002);
        t2 = t + 6;
        push_exp(t2 + 1, 16'h0001); push_exp(t2 + 5, 16'h0002); push_exp(t2 + 7, 16'h0004);
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        idle(5);
        bus_cycle(1'b1, A_CTRL, 16'h0001, 1'b0);
        idle(12);
        check("restart_queue_drained", exp_q.size(), 32'd0);
        check("restart_done_count", done_cnt - d0, 32'd1);
        check("restart_done_cycle", done_cyc, t2 + 10);
        read_chk("restart_ctrl", A_CTRL, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
